// File: rtl/gl_cmd_fetch.sv
// GL command fetch/parse stage: walks the command stream in the instruction BRAM and
// emits each command as a header beat followed by payload beats of up to four words.
module gl_cmd_fetch #(
  parameter int unsigned START_ADDR  = 0,
  parameter int unsigned MEM_DEPTH   = 45,
  parameter int unsigned MAX_PAYLOAD = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [31:0]  addr1,
  output logic [31:0]  addr2,
  input  logic [31:0]  read0,
  input  logic [31:0]  read1,
  input  logic [31:0]  read2,
  input  logic [31:0]  read3,
  input  logic [31:0]  read4,
  output logic         cmd_valid,
  input  logic         cmd_ready,
  output logic         cmd_first,
  output logic         cmd_last,
  output logic [7:0]   cmd_opcode,
  output logic [7:0]   cmd_imm,
  output logic [7:0]   cmd_len,
  output logic [127:0] cmd_data,
  output logic [2:0]   cmd_cnt,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam logic [31:0] START_W = 32'(START_ADDR);
  localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);
  localparam logic [32:0] DEPTH_X = 33'(MEM_DEPTH);
  localparam logic [7:0]  MAXP_W  = 8'(MAX_PAYLOAD);
  localparam logic [7:0]  OP_FLUSH = 8'h05;

  typedef enum logic [2:0] {IDLE, HDR, PAY, HALT, ERR} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [7:0]  remain, remain_nxt;
  logic [7:0]  op_q, op_nxt;
  logic [7:0]  len_q, len_nxt;

  logic [7:0]   hdr_len;
  logic [32:0]  hdr_end;
  logic         hdr_fault;
  logic [2:0]   pay_cnt;
  logic [127:0] pay_data;
  logic         unused_hdr;

  assign unused_hdr = ^read0[30:16];

  // Header decode; the 33-bit end address keeps pc+len from wrapping past the depth check.
  assign hdr_len   = read0[31] ? read0[15:8] : 8'd0;
  assign hdr_end   = {1'b0, pc} + {25'd0, hdr_len};
  assign hdr_fault = (pc >= DEPTH_W) || (hdr_len > MAXP_W) || (hdr_end >= DEPTH_X);

  assign pay_cnt  = (remain > 8'd3) ? 3'd4 : remain[2:0];
  assign pay_data = {(pay_cnt >= 3'd1) ? read1 : 32'd0,
                     (pay_cnt >= 3'd2) ? read2 : 32'd0,
                     (pay_cnt >= 3'd3) ? read3 : 32'd0,
                     (pay_cnt >= 3'd4) ? read4 : 32'd0};

  assign addr1 = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= START_W;
      remain <= 8'd0;
      op_q   <= 8'd0;
      len_q  <= 8'd0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      remain <= remain_nxt;
      op_q   <= op_nxt;
      len_q  <= len_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    remain_nxt = remain;
    op_nxt     = op_q;
    len_nxt    = len_q;
    addr2      = 32'd0;
    cmd_valid  = 1'b0;
    cmd_first  = 1'b0;
    cmd_last   = 1'b0;
    cmd_opcode = 8'd0;
    cmd_imm    = 8'd0;
    cmd_len    = 8'd0;
    cmd_data   = 128'd0;
    cmd_cnt    = 3'd0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = HDR;
          pc_nxt    = START_W;
        end
      end
      HDR: begin
        busy = 1'b1;
        if (hdr_fault) begin
          state_nxt = ERR;
        end else begin
          cmd_valid  = 1'b1;
          cmd_first  = 1'b1;
          cmd_last   = (hdr_len == 8'd0);
          cmd_opcode = read0[7:0];
          cmd_imm    = read0[31] ? 8'd0 : read0[15:8];
          cmd_len    = hdr_len;
          if (cmd_ready) begin
            op_nxt  = read0[7:0];
            len_nxt = hdr_len;
            pc_nxt  = pc + 32'd1;
            if (hdr_len != 8'd0) begin
              remain_nxt = hdr_len;
              state_nxt  = PAY;
            end else if (read0[7:0] == OP_FLUSH) begin
              state_nxt = HALT;
            end
          end
        end
      end
      PAY: begin
        busy       = 1'b1;
        addr2      = pc;
        cmd_valid  = 1'b1;
        cmd_last   = (remain <= 8'd4);
        cmd_opcode = op_q;
        cmd_len    = len_q;
        cmd_cnt    = pay_cnt;
        cmd_data   = pay_data;
        if (cmd_ready) begin
          pc_nxt     = pc + 32'(pay_cnt);
          remain_nxt = remain - 8'(pay_cnt);
          if (remain <= 8'd4) state_nxt = HDR;
        end
      end
      HALT: begin
        done = 1'b1;
        if (start) begin
          state_nxt = HDR;
          pc_nxt    = START_W;
        end
      end
      ERR: begin
        err = 1'b1;
        if (start) begin
          state_nxt = HDR;
          pc_nxt    = START_W;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gl_cmd_fetch.sv
// Directed bench for gl_cmd_fetch: a BRAM model, a stream-level reference parser and a
// per-cycle beat comparator.
module tb_gl_cmd_fetch;

  localparam int DEPTH = 45;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cmd_ready = 1'b0;
  logic [31:0]  addr1, addr2, read0, read1, read2, read3, read4;
  logic         cmd_valid, cmd_first, cmd_last, busy, done, err;
  logic [7:0]   cmd_opcode, cmd_imm, cmd_len;
  logic [127:0] cmd_data;
  logic [2:0]   cmd_cnt;

  logic [31:0] mem [0:63];

  typedef struct packed {
    logic         first;
    logic         last;
    logic [7:0]   op;
    logic [7:0]   imm;
    logic [7:0]   len;
    logic [2:0]   cnt;
    logic [31:0]  addr;
    logic [127:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    exp_end;
  int    checks = 0;
  int    errors = 0;
  int    popped = 0;
  int    cyc = 0;
  int    first_pop = 0;
  int    last_pop = 0;

  gl_cmd_fetch #(.START_ADDR(0), .MEM_DEPTH(DEPTH), .MAX_PAYLOAD(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .addr1(addr1), .addr2(addr2),
    .read0(read0), .read1(read1), .read2(read2), .read3(read3), .read4(read4),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_first(cmd_first), .cmd_last(cmd_last),
    .cmd_opcode(cmd_opcode), .cmd_imm(cmd_imm), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .cmd_cnt(cmd_cnt), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Out-of-range addresses return garbage so any unmasked lane shows up.
  function automatic logic [31:0] rd(input logic [31:0] a);
    return (a < DEPTH) ? mem[a[5:0]] : 32'hDEAD_BEEF;
  endfunction

  assign read0 = rd(addr1);
  assign read1 = rd(addr2);
  assign read2 = rd(addr2 + 32'd1);
  assign read3 = rd(addr2 + 32'd2);
  assign read4 = rd(addr2 + 32'd3);

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, expv);
    end
  endtask

  // Reference parser: turns the memory image into the beat list and the terminal outcome.
  function automatic void build_expected();
    int unsigned pc;
    logic [31:0] h;
    int len, n;
    beat_t b;
    exp_q.delete();
    pc = 0;
    exp_end = 0;
    for (int guard = 0; guard < 100 && exp_end == 0; guard++) begin
      if (pc >= DEPTH) begin exp_end = 2; break; end
      h = mem[pc];
      len = h[31] ? int'(h[15:8]) : 0;
      if (len > 16 || pc + len >= DEPTH) begin exp_end = 2; break; end
      b = '0;
      b.first = 1'b1;
      b.last  = (len == 0);
      b.op    = h[7:0];
      b.imm   = h[31] ? 8'd0 : h[15:8];
      b.len   = 8'(len);
      b.addr  = pc;
      exp_q.push_back(b);
      for (int k = 0; k < len; k += 4) begin
        n = (len - k < 4) ? len - k : 4;
        b = '0;
        b.last = (k + 4 >= len);
        b.op   = h[7:0];
        b.len  = 8'(len);
        b.cnt  = 3'(n);
        b.addr = pc + 1 + k;
        for (int j = 0; j < n; j++) b.data[127 - 32*j -: 32] = mem[pc + 1 + k + j];
        exp_q.push_back(b);
      end
      pc += 1 + len;
      if (len == 0 && h[7:0] == 8'h05) exp_end = 1;
    end
  endfunction

  always @(negedge clk) begin
    beat_t act;
    if (rst_n && cmd_valid) begin
      act = {cmd_first, cmd_last, cmd_opcode, cmd_imm, cmd_len, cmd_cnt,
             cmd_first ? addr1 : addr2, cmd_data};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat act=%0h", act);
      end else begin
        if (act !== exp_q[0]) begin
          errors++;
          $display("FAIL beat%0d act=%0h exp=%0h", popped, act, exp_q[0]);
        end
        if (cmd_ready) begin
          void'(exp_q.pop_front());
          if (popped == 0) first_pop = cyc;
          last_pop = cyc;
          popped++;
        end
      end
    end
  end

  task automatic load_prog1();
    for (int i = 0; i < 64; i++) mem[i] = 32'hBAD0_0000 + i;
    mem[0] = 32'h0000_0110;
    mem[1] = 32'h8000_1011;
    for (int i = 2; i < 18; i++) mem[i] = 32'h1000 + i;
    for (int c = 0; c < 3; c++) begin
      mem[18 + 8*c] = 32'h8000_0304;
      mem[22 + 8*c] = 32'h8000_0303;
      for (int j = 1; j < 4; j++) begin
        mem[18 + 8*c + j] = 32'h1000 + 18 + 8*c + j;
        mem[22 + 8*c + j] = 32'h1000 + 22 + 8*c + j;
      end
    end
    mem[42] = 32'h0000_0005;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_popped(input int n);
    int k = 0;
    while (popped < n && k < 500) begin @(negedge clk); #1; k++; end
    check("wait_popped_timeout", k < 500, 1);
  endtask

  task automatic wait_end(input string name);
    int k = 0;
    while (!(exp_q.size() == 0 && (done || err)) && k < 2000) begin @(negedge clk); #1; k++; end
    check({name, "_timeout"}, k < 2000, 1);
    check({name, "_done"}, done, exp_end == 1);
    check({name, "_err"}, err, exp_end == 2);
    check({name, "_busy"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    load_prog1();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", cmd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_addr1", addr1, 0);
    check("rst_data", cmd_data, 0);

    // Full program, ready held high
    build_expected();
    check("m1_beats", exp_q.size(), 19);
    check("m1_end", exp_end, 1);
    check("m1_hdr0", {exp_q[0].op, exp_q[0].imm, exp_q[0].last}, {8'h10, 8'h01, 1'b1});
    check("m1_rot_b1", exp_q[2].data, {32'h1002, 32'h1003, 32'h1004, 32'h1005});
    check("m1_rot_b4", {exp_q[5].cnt, exp_q[5].last, exp_q[5].addr}, {3'd4, 1'b1, 32'd14});
    check("m1_col_b1", {exp_q[7].cnt, exp_q[7].data}, {3'd3, 32'h1013, 32'h1014, 32'h1015, 32'h0});
    cmd_ready = 1'b1;
    popped = 0;
    pulse_start();
    check("s1_latency", cmd_valid, 1);
    wait_end("s1");
    check("s1_count", popped, 19);
    check("s1_consecutive", last_pop - first_pop, 18);

    // Backpressure on the second rotate payload beat (window base 6)
    build_expected();
    popped = 0;
    pulse_start();
    wait_popped(3);
    @(posedge clk); #1 cmd_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("s2_stall_addr2", addr2, 6);
      check("s2_stall_valid", cmd_valid, 1);
    end
    @(posedge clk); #1 cmd_ready = 1'b1;
    @(posedge clk); #1;
    check("s2_resume_addr2", addr2, 10);
    wait_end("s2");

    // Oversized payload at pc 0
    mem[0] = 32'h8000_2011;
    build_expected();
    check("m3_beats", exp_q.size(), 0);
    check("m3_end", exp_end, 2);
    pulse_start();
    check("s3_no_valid", cmd_valid, 0);
    wait_end("s3");
    pulse_start();
    check("s3_err_clear", err, 0);
    check("s3_busy", busy, 1);
    check("s3_refetch_pc", addr1, 0);
    wait_end("s3b");

    // Vertex stream with no Flush runs into the end of memory
    for (int i = 0; i < 64; i++) mem[i] = 32'h2000 + i;
    for (int i = 0; i < 12; i++) mem[4*i] = 32'h8000_0303;
    build_expected();
    check("m4_beats", exp_q.size(), 22);
    check("m4_end", exp_end, 2);
    check("m4_last_addr", exp_q[21].addr, 41);
    popped = 0;
    pulse_start();
    wait_end("s4");
    check("s4_count", popped, 22);
    check("s4_pc", addr1, 44);

    // Asynchronous reset in the middle of the rotate payload
    load_prog1();
    build_expected();
    popped = 0;
    pulse_start();
    wait_popped(4);
    @(posedge clk); #1;
    check("s5_pre_addr2", addr2, 10);
    #2 rst_n = 1'b0;
    #1;
    check("s5_valid_drop", cmd_valid, 0);
    check("s5_busy_drop", busy, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("s5_idle_valid", cmd_valid, 0);
    check("s5_idle_busy", busy, 0);
    check("s5_idle_flags", {done, err}, 0);
    build_expected();
    popped = 0;
    pulse_start();
    check("s5_restart_hdr", {cmd_valid, cmd_first, addr1}, {1'b1, 1'b1, 32'd0});
    wait_end("s5");
    check("s5_count", popped, 19);

    // start mid-command is ignored
    build_expected();
    popped = 0;
    pulse_start();
    wait_popped(6);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_end("s6");
    check("s6_count", popped, 19);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
